// File: rtl/store_commit_buffer_if.sv
// Data-memory write port of the store commit buffer.
// The buffer drives req/addr/data; memory returns ack.
interface store_commit_buffer_if #(
    parameter int ADDR_W = 48,
    parameter int DATA_W = 64
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_data,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_data,
        output mem_ack
    );
endinterface

// File: rtl/store_commit_buffer.sv
// In-order committed-store FIFO with memory drain and load forwarding.
// Define STORE_COALESCE_EN to merge pushes into matching non-head entries.
module store_commit_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 48,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       commit_ready_mem,
    input  logic [ADDR_W-1:0]          Address_in,
    input  logic [DATA_W-1:0]          Data_in,
    output logic                       full_out,
    output logic                       empty_out,
    output logic [$clog2(DEPTH):0]     count_out,
    store_commit_buffer_if.master      mem,
    input  logic                       load_valid,
    input  logic [ADDR_W-1:0]          load_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, REQ} state_t;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count, cnt_nxt;
    state_t            state, state_nxt;

    logic push, pop, coal_hit;
    logic [PTR_W-1:0] f_idx;

    assign full_out  = (count == CNT_W'(DEPTH));
    assign empty_out = (count == '0);
    assign count_out = count;

`ifdef STORE_COALESCE_EN
    logic [PTR_W-1:0] c_idx, c_scan;
    logic             coal_wr;

    // Scan oldest to youngest past the head so the youngest match wins.
    always_comb begin
        coal_hit = 1'b0;
        c_idx    = '0;
        c_scan   = '0;
        for (int i = 1; i < DEPTH; i++) begin
            c_scan = head + PTR_W'(i);
            if (state == REQ && valid_q[c_scan] &&
                addr_q[c_scan] == Address_in) begin
                coal_hit = 1'b1;
                c_idx    = c_scan;
            end
        end
    end

    assign coal_wr = commit_ready_mem && coal_hit;
`else
    assign coal_hit = 1'b0;
`endif

    assign push = commit_ready_mem && !full_out && !coal_hit;
    assign pop  = (state == REQ) && mem.mem_ack;

    always_comb begin
        cnt_nxt = count;
        unique case ({push, pop})
            2'b10:   cnt_nxt = count + 1'b1;
            2'b01:   cnt_nxt = count - 1'b1;
            default: cnt_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (count != '0) state_nxt = REQ;
            REQ:  if (pop && cnt_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
            state   <= IDLE;
        end else begin
            count <= cnt_nxt;
            state <= state_nxt;
            if (push) begin
                tail          <= tail + 1'b1;
                valid_q[tail] <= 1'b1;
            end
            if (pop) begin
                head          <= head + 1'b1;
                valid_q[head] <= 1'b0;
            end
        end
    end

    // Payload needs no reset; valid_q and state gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= Address_in;
            data_q[tail] <= Data_in;
        end
`ifdef STORE_COALESCE_EN
        if (coal_wr) data_q[c_idx] <= Data_in;
`endif
    end

    assign mem.mem_req  = (state == REQ);
    assign mem.mem_addr = (state == REQ) ? addr_q[head] : '0;
    assign mem.mem_data = (state == REQ) ? data_q[head] : '0;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        f_idx    = '0;
        if (load_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                f_idx = head + PTR_W'(i);
                if (valid_q[f_idx] && addr_q[f_idx] == load_addr) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[f_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_store_commit_buffer.sv
// Scoreboard bench for store_commit_buffer.
// Coalescing checks run only when STORE_COALESCE_EN is defined.
module tb_store_commit_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 48;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              commit_ready_mem = 1'b0;
    logic [ADDR_W-1:0] Address_in = '0;
    logic [DATA_W-1:0] Data_in = '0;
    logic              full_out, empty_out;
    logic [2:0]        count_out;
    logic              load_valid = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    store_commit_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

    store_commit_buffer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .commit_ready_mem(commit_ready_mem),
        .Address_in(Address_in),
        .Data_in(Data_in),
        .full_out(full_out),
        .empty_out(empty_out),
        .count_out(count_out),
        .mem(mif),
        .load_valid(load_valid),
        .load_addr(load_addr),
        .fwd_hit(fwd_hit),
        .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t sb[$];
    int   mcnt = 0;
    bit   m_req = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fwd(input logic [ADDR_W-1:0] a, input bit hit,
                       input logic [DATA_W-1:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        #1;
        check("fwd_hit", 64'(fwd_hit), 64'(hit));
        check("fwd_data", fwd_data, d);
        load_valid = 1'b0;
    endtask

    // One clock with optional push and ack; the model predicts the result.
    task automatic cycle(input bit p, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input bit ack);
        bit acc, pop, coal;
        int ci, nc;
        commit_ready_mem = p;
        Address_in       = a;
        Data_in          = d;
        mif.mem_ack      = ack;
        coal = 1'b0;
        ci   = -1;
`ifdef STORE_COALESCE_EN
        if (p && m_req)
            for (int i = 1; i < sb.size(); i++)
                if (sb[i].a == a) ci = i;
        coal = (ci > 0);
`endif
        acc = p && !coal && (mcnt < DEPTH);
        pop = ack && m_req;
        if (pop) begin
            check("drain_addr", 64'(mif.mem_addr), 64'(sb[0].a));
            check("drain_data", mif.mem_data, sb[0].d);
        end
        if (coal) sb[ci].d = d;
        if (pop) void'(sb.pop_front());
        if (acc) sb.push_back({a, d});
        nc    = mcnt + int'(acc) - int'(pop);
        m_req = m_req ? !(pop && nc == 0) : (mcnt > 0);
        mcnt  = nc;
        #1;
        tick;
        commit_ready_mem = 1'b0;
        mif.mem_ack      = 1'b0;
        check("count", 64'(count_out), 64'(mcnt));
        check("mem_req", 64'(mif.mem_req), 64'(m_req));
        check("full", 64'(full_out), 64'(mcnt == DEPTH));
        check("empty", 64'(empty_out), 64'(mcnt == 0));
        if (!m_req) check("idle_addr", 64'(mif.mem_addr), 64'(0));
    endtask

    task automatic drain;
        for (int k = 0; k < 20 && sb.size() > 0; k++) cycle(1'b0, '0, '0, 1'b1);
        check("drain_done", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        mif.mem_ack = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_count", 64'(count_out), 64'(0));
        check("rst_empty", 64'(empty_out), 64'(1));
        check("rst_full", 64'(full_out), 64'(0));
        check("rst_req", 64'(mif.mem_req), 64'(0));
        check("rst_addr", 64'(mif.mem_addr), 64'(0));
        check("rst_data", mif.mem_data, 64'(0));
        fwd(48'h0, 1'b0, 64'h0);

        // single store round trip
        cycle(1'b1, 48'h100, 64'h11, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        check("t1_addr", 64'(mif.mem_addr), 64'h100);
        check("t1_data", mif.mem_data, 64'h11);
        cycle(1'b0, '0, '0, 1'b1);

        // fill, drop on full, drain in order
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 48'(i * 'h100), 64'(i), 1'b0);
        cycle(1'b1, 48'h500, 64'h5, 1'b0);
        drain;

        // push blocked on full even when popping
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 48'(i * 'h10), 64'(i + 'h20), 1'b0);
        cycle(1'b1, 48'h500, 64'h55, 1'b1);
        check("t3_count", 64'(count_out), 64'(3));
        drain;

        // forwarding picks youngest match
        cycle(1'b1, 48'h40, 64'hAA, 1'b0);
        cycle(1'b1, 48'h40, 64'hBB, 1'b0);
        fwd(48'h40, 1'b1, 64'hBB);
        fwd(48'h48, 1'b0, 64'h0);
        load_addr = 48'h40;
        #1;
        check("fwd_off_hit", 64'(fwd_hit), 64'(0));
        check("fwd_off_data", fwd_data, 64'h0);
        commit_ready_mem = 1'b1;
        Address_in = 48'h60;
        Data_in = 64'h66;
        fwd(48'h60, 1'b0, 64'h0);
        cycle(1'b1, 48'h60, 64'h66, 1'b0);
        fwd(48'h60, 1'b1, 64'h66);
        drain;

        // pointer wrap with interleaved acks
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 48'h1000 + 48'(i * 8), 64'hD0 + 64'(i), i >= 2);
        drain;

        // reset mid-drain; late ack ignored
        cycle(1'b1, 48'h700, 64'h77, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        check("t6_req_pre", 64'(mif.mem_req), 64'(1));
        rst = 1'b1;
        mif.mem_ack = 1'b1;
        tick;
        rst = 1'b0;
        mif.mem_ack = 1'b0;
        sb.delete();
        mcnt = 0;
        m_req = 1'b0;
        check("t6_req", 64'(mif.mem_req), 64'(0));
        check("t6_empty", 64'(empty_out), 64'(1));
        fwd(48'h700, 1'b0, 64'h0);
        cycle(1'b0, '0, '0, 1'b1);

`ifdef STORE_COALESCE_EN
        cycle(1'b1, 48'h10, 64'h1, 1'b0);
        cycle(1'b1, 48'h20, 64'h2, 1'b0);
        cycle(1'b1, 48'h20, 64'hCC, 1'b0);
        check("coal_count", 64'(count_out), 64'(2));
        fwd(48'h20, 1'b1, 64'hCC);
        drain;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Sits directly downstream of the reorder buffer's memory-commit path.
- Accepts committed stores (address plus data) when the ROB retires a memory op, holds them in a FIFO, and drains them in order to the data-memory write port using a req/ack handshake.
- Provides a combinational store-to-load forwarding lookup so younger loads see committed-but-not-yet-written data.
- Asserts a full flag so the ROB holds its commit while the buffer is saturated.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, >=2)
- ADDR_W, 48, store/load address width
- DATA_W, 64, store data width

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  synchronous active-high reset
- commit_ready_mem  input  1  ROB is retiring a store this cycle
- Address_in  input  ADDR_W  committed store address
- Data_in  input  DATA_W  committed store data
- full_out  output  1  buffer cannot accept a store this cycle; ROB must hold the commit
- empty_out  output  1  no stores buffered
- count_out  output  $clog2(DEPTH)+1  number of valid entries
- mem_req  output  1  write request to data memory
- mem_addr  output  ADDR_W  write address, valid while mem_req=1
- mem_data  output  DATA_W  write data, valid while mem_req=1
- mem_ack  input  1  memory accepted the write; sampled at posedge only while mem_req=1
- load_valid  input  1  forwarding lookup request
- load_addr  input  ADDR_W  load address to match
- fwd_hit  output  1  some buffered entry matches load_addr
- fwd_data  output  DATA_W  data of the youngest matching entry

Behaviour:
- Storage: circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap DEPTH-1 -> 0, plus count (0..DEPTH).
- Reset (rst=1 at posedge, overrides all other inputs):
  - head=tail=count=0, all entry valid bits cleared
  - mem_req=0, mem_addr=0, mem_data=0
  - full_out=0, empty_out=1, count_out=0
  - fwd_hit=0 and fwd_data=0 for all inputs while empty
- Reset mid-drain: the outstanding request is abandoned; mem_req is 0 the cycle after reset. A mem_ack arriving after reset is ignored.
- full_out = (count==DEPTH); empty_out = (count==0). Both combinational from registered count.
- Push: at posedge when commit_ready_mem=1 and full_out=0, write the entry at tail, tail++, count++.
  - Push while full_out=1 is dropped with no state change; the ROB must re-present it.
- Drain FSM, two states:
  - IDLE: mem_req=0. Move to REQ the cycle after count becomes nonzero; mem_req rises one cycle after the first push at the earliest.
  - REQ: mem_req=1, mem_addr/mem_data = head entry, held stable until acked.
    - On posedge with mem_ack=1: pop head (head++, count--).
    - If count after the pop is >0, stay in REQ and present the new head next cycle (back-to-back writes).
    - Otherwise go to IDLE.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance. When full, the push is still blocked because full_out is evaluated before the pop.
- Forwarding (combinational):
  - When load_valid=1, compare load_addr against every valid entry, including the head currently being drained.
  - fwd_hit=1 if any entry matches; fwd_data comes from the youngest match, nearest the tail.
  - A store being pushed in the same cycle is not visible until the next cycle.
  - load_valid=0 forces fwd_hit=0 and fwd_data=0.
- Address compare is full ADDR_W equality; no partial or byte-overlap matching.

Optional Feature:
- Macro STORE_COALESCE_EN.
- Defined:
  - A push whose Address_in equals a valid entry other than the head while mem_req=1 overwrites that entry's data in place.
  - count and tail are unchanged, and full_out does not block a coalescing push.
  - If several entries match, the youngest is overwritten.
- Undefined: every accepted push allocates a new entry.

Test Plan:
1. Reset, then push A=0x100/D=0x11 -> full_out=0, count_out=1; mem_req=1 next cycle with mem_addr=0x100, mem_data=0x11; ack -> count_out=0, mem_req=0 the following cycle.
2. Four pushes with mem_ack=0 -> full_out=1, count_out=4; fifth push 0x500 dropped; ack four times -> addresses drain in order 0x100, 0x200, 0x300, 0x400.
3. Full buffer, commit_ready_mem=1 and mem_ack=1 in the same cycle -> push dropped, count_out=3.
4. Push 0x40/0xAA then 0x40/0xBB, load_valid=1 with load_addr=0x40 -> fwd_hit=1, fwd_data=0xBB; load_addr=0x48 -> fwd_hit=0.
5. Eight pushes with acks interleaved so the pointers wrap past DEPTH-1 -> write order and data are preserved, count_out never exceeds 4.
6. rst asserted while mem_req=1 -> next cycle mem_req=0, empty_out=1, fwd_hit=0. With STORE_COALESCE_EN defined: entries 0x10, 0x20, then push 0x20/0xCC -> count_out stays 2, forwarding 0x20 returns 0xCC.
